// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit queue in front of it.
// The serial output is registered one cycle behind the frame state machine.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 txd_out,
    output logic                 busy,
    output logic                 full,
    output logic                 overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic        STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [PW:0] DEPTH_CNT = FIFO_DEPTH[PW:0];

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;
    logic [2:0]           state_q, state_d;
    logic [15:0]          clk_cnt_q, clk_cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 full_q, full_d;
    logic                 ovf_q, ovf_d;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic [DATA_BITS-1:0] head;

    assign push    = load && !full_q;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (clk_cnt_q == BIT_LAST);

    // Frame sequencer; a pop always restarts the bit timer in START.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = '0;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        pop        = 1'b0;

        if (state_q != S_IDLE) begin
            clk_cnt_d = bit_end ? 16'd0 : clk_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 4'd0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        state_d    = (PARITY == 0) ? S_STOP : S_PARITY;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d    = S_STOP;
                    stop_idx_d = 1'b0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        if (count_q != '0) begin
                            pop = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop) begin
            state_d   = S_START;
            shift_d   = head;
            par_d     = (^head) ^ (PARITY == 1);
            clk_cnt_d = 16'd0;
        end
    end

    // Queue bookkeeping and the registered outputs.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + (PW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PW+1)'(1);
        end
        full_d = (count_d == DEPTH_CNT);
        ovf_d  = load && full_q;
        // Busy lingers one extra cycle so it covers the lagging line output.
        busy_d = (count_d != '0) || (state_d != S_IDLE) || (state_q != S_IDLE);
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
            S_PARITY: txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign txd_out  = txd_q;
    assign busy     = busy_q;
    assign full     = full_q;
    assign overflow = ovf_q;

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1302, clock cycles per serial bit (legal 2..65535); default gives 76800 baud at 100 MHz.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (legal 1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, transmit queue entries (power of 2, 2..64).
REQ-006 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port load, input, 1, one-cycle request to enqueue data_in.
REQ-009 SHALL have port data_in, input, DATA_BITS, character to enqueue.
REQ-010 SHALL have port txd_out, output, 1, serial line; idle high.
REQ-011 SHALL have port busy, output, 1, high while a frame is on the line or the FIFO is non-empty.
REQ-012 SHALL have port full, output, 1, high when the FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port overflow, output, 1, one-cycle pulse when a load is dropped.

Function
REQ-014 SHALL sample load at each rising edge; if load=1 and full=0, SHALL write data_in into the FIFO at that edge.
REQ-015 SHALL drop a load when full=1 at that edge, even if a pop occurs in the same cycle, and SHALL pulse overflow high for exactly the next cycle.
REQ-016 SHALL allow a write and a pop in the same cycle; occupancy then stays unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY=0.
REQ-018 In IDLE with the FIFO non-empty, SHALL pop the head entry into the shift register and enter START at the same edge.
REQ-019 SHALL drive txd_out low beginning the second rising edge after an accepted load into an idle, empty block: latency 2 cycles.
REQ-020 SHALL hold every bit (start, data, parity, stop) for exactly CLKS_PER_BIT cycles, using a bit-period counter reset at each bit boundary.
REQ-021 SHALL send data bits LSB first, DATA_BITS of them.
REQ-022 SHALL send the parity bit as the XOR of the data bits (even) or its inverse (odd).
REQ-023 SHALL send STOP_BITS high bits; at the end of the final stop bit, SHALL pop the next entry and enter START at the same edge when the FIFO is non-empty, else enter IDLE with txd_out high.
REQ-024 Back-to-back frames SHALL have zero idle cycles between the last stop bit and the next start bit.
REQ-025 SHALL hold busy=1 from the edge accepting a load until the edge ending the final stop bit with the FIFO empty.
REQ-026 SHALL ignore data_in changes after the accept edge; the queued value is used.
REQ-027 SHALL keep all outputs registered (no combinational path from load or data_in to any output).

Reset
REQ-028 While rst=1 at a rising edge, SHALL set txd_out=1, busy=0, full=0, overflow=0, state IDLE, all counters and FIFO pointers 0.
REQ-029 A reset mid-frame SHALL abort the frame, discard all queued entries, and drive txd_out high from the next cycle.
REQ-030 SHALL ignore load during any cycle with rst=1.

Verification
REQ-031 Defaults, load 0x55 once -> txd_out = 0,1,0,1,0,1,0,1,0,1, each held 1302 cycles; start at load edge +2; busy falls 13020 cycles after start.
REQ-032 PARITY=2, load 0x55 -> parity bit 0; PARITY=1, load 0x55 -> parity bit 1; frame 11 bits.
REQ-033 Load 0x55, then 0xCC 11709 cycles later -> 20 contiguous bits, 0xCC start bit immediately after 0x55 stop bit; busy stays high throughout.
REQ-034 CLKS_PER_BIT=4, FIFO_DEPTH=4: loads 0x01..0x06 on 6 consecutive cycles -> full high after the 5th, 6th dropped, overflow one-cycle pulse, frames 0x01..0x05 sent in order.
REQ-035 CLKS_PER_BIT=4, DATA_BITS=7, STOP_BITS=2: load 0x7F -> 0, seven 1s, then two stop bits; 10 bits of 4 cycles each.
REQ-036 rst=1 during bit 3 of a frame with 2 entries queued -> txd_out=1 next cycle, busy=0, full=0; no further frames.
